// File: rtl/decodificador_hamming.sv
// rtl/decodificador_hamming.sv - Hamming(7,4) SEC decoder, 2-stage valid/ready pipeline
module decodificador_hamming #(
    parameter int ANCHO_CNT = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           cod_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [3:0]           datos_out,
    output logic [2:0]           sindrome,
    output logic                 error_det,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 borrar_cnt,
    output logic [ANCHO_CNT-1:0] contador_err
);

    logic                 v1_q, v1_d;
    logic [6:0]           cod1_q, cod1_d;
    logic                 out_valid_q, out_valid_d;
    logic [3:0]           datos_q, datos_d;
    logic [2:0]           sind_q, sind_d;
    logic                 err_q, err_d;
    logic [ANCHO_CNT-1:0] cnt_q, cnt_d;

    logic       s2_ready, s1_ready, in_fire, s2_load, out_fire;
    logic [2:0] syn;
    logic [6:0] corregido;

    always_comb begin
        s2_ready = !out_valid_q || out_ready;
        s1_ready = !v1_q || s2_ready;
        in_fire  = in_valid && s1_ready;
        s2_load  = v1_q && s2_ready;
        out_fire = out_valid_q && out_ready;

        syn[0] = cod1_q[0] ^ cod1_q[2] ^ cod1_q[4] ^ cod1_q[6];
        syn[1] = cod1_q[1] ^ cod1_q[2] ^ cod1_q[5] ^ cod1_q[6];
        syn[2] = cod1_q[3] ^ cod1_q[4] ^ cod1_q[5] ^ cod1_q[6];
        // Syndrome is the 1-based position of the flipped bit
        corregido = cod1_q;
        if (syn != 3'd0) begin
            corregido = cod1_q ^ (7'd1 << (syn - 3'd1));
        end

        v1_d   = v1_q;
        cod1_d = cod1_q;
        if (in_fire) begin
            v1_d   = 1'b1;
            cod1_d = cod_in;
        end else if (s2_load) begin
            v1_d = 1'b0;
        end

        out_valid_d = out_valid_q;
        datos_d     = datos_q;
        sind_d      = sind_q;
        err_d       = err_q;
        if (s2_ready) begin
            out_valid_d = v1_q;
        end
        if (s2_load) begin
            datos_d = {corregido[6], corregido[5], corregido[4], corregido[2]};
            sind_d  = syn;
            err_d   = (syn != 3'd0);
        end

        // Clear wins over a simultaneous increment; saturate instead of wrapping
        cnt_d = cnt_q;
        if (borrar_cnt) begin
            cnt_d = '0;
        end else if (out_fire && err_q && (cnt_q != {ANCHO_CNT{1'b1}})) begin
            cnt_d = cnt_q + ANCHO_CNT'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            cod1_q      <= 7'd0;
            out_valid_q <= 1'b0;
            datos_q     <= 4'd0;
            sind_q      <= 3'd0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            v1_q        <= v1_d;
            cod1_q      <= cod1_d;
            out_valid_q <= out_valid_d;
            datos_q     <= datos_d;
            sind_q      <= sind_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready     = s1_ready;
    assign out_valid    = out_valid_q;
    assign datos_out    = datos_q;
    assign sindrome     = sind_q;
    assign error_det    = err_q;
    assign contador_err = cnt_q;

endmodule
